// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte streams,
// with burst limiting and a start-handshake timeout.
module uart_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int DATA_W        = 8,
  parameter int MAX_BURST     = 16,
  parameter int START_TIMEOUT = 64
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_busy,
  output logic                     grant_valid,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     err_timeout
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam int TO_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_WAIT_DONE} state_t;

  state_t            r_state, w_state;
  logic              r_tx_start, w_tx_start;
  logic [DATA_W-1:0] r_tx_data, w_tx_data;
  logic              r_grant_valid, w_grant_valid;
  logic [ID_W-1:0]   r_grant_id, w_grant_id;
  logic              r_err_timeout, w_err_timeout;
  logic [BC_W-1:0]   r_burst_cnt, w_burst_cnt;
  logic [ID_W-1:0]   r_last_id, w_last_id;
  logic              r_last_cap, w_last_cap;
  logic [TO_W-1:0]   r_to_cnt, w_to_cnt;
  logic [N_REQ-1:0]  w_ready;
  logic [ID_W:0]     w_pick;
  logic              w_release;

  // Returns {found, id}: the first valid requester after 'last', wrapping.
  // Scanning from farthest to nearest lets the nearest hit win.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] vld,
                                            input logic [ID_W-1:0]  last);
    logic [ID_W:0] res;
    int            idx;
    res = {1'b0, last};
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(last) + i) % N_REQ;
      if (vld[idx]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    w_state       = r_state;
    w_tx_start    = r_tx_start;
    w_tx_data     = r_tx_data;
    w_grant_valid = r_grant_valid;
    w_grant_id    = r_grant_id;
    w_err_timeout = 1'b0;
    w_burst_cnt   = r_burst_cnt;
    w_last_id     = r_last_id;
    w_last_cap    = r_last_cap;
    w_to_cnt      = r_to_cnt;
    w_ready       = '0;
    w_release     = 1'b0;
    w_pick        = rr_pick(req_valid, r_last_id);
    case (r_state)
      S_IDLE: begin
        if (w_pick[ID_W]) begin
          w_grant_valid = 1'b1;
          w_grant_id    = w_pick[ID_W-1:0];
          w_burst_cnt   = '0;
          w_state       = S_LOAD;
        end
      end
      S_LOAD: begin
        if (req_valid[r_grant_id]) begin
          w_ready[r_grant_id] = 1'b1;
          w_tx_data   = req_data[int'(r_grant_id)*DATA_W +: DATA_W];
          w_last_cap  = req_last[r_grant_id];
          w_burst_cnt = r_burst_cnt + BC_W'(1);
          w_to_cnt    = '0;
          w_tx_start  = 1'b1;
          w_state     = S_START;
        end else begin
          w_release = 1'b1;
        end
      end
      S_START: begin
        // A busy already high on entry is taken as the acknowledge.
        if (tx_busy) begin
          w_tx_start = 1'b0;
          w_state    = S_WAIT_DONE;
        end else if (r_to_cnt == TO_W'(START_TIMEOUT - 1)) begin
          w_err_timeout = 1'b1;
          w_tx_start    = 1'b0;
          w_release     = 1'b1;
        end else begin
          w_to_cnt = r_to_cnt + TO_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (r_last_cap || (r_burst_cnt == BC_W'(MAX_BURST))) w_release = 1'b1;
          else                                                  w_state   = S_LOAD;
        end
      end
      default: w_state = S_IDLE;
    endcase
    if (w_release) begin
      w_grant_valid = 1'b0;
      w_last_id     = r_grant_id;
      w_state       = S_IDLE;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state       <= S_IDLE;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_err_timeout <= 1'b0;
      r_burst_cnt   <= '0;
      r_last_id     <= ID_W'(N_REQ - 1);
      r_last_cap    <= 1'b0;
      r_to_cnt      <= '0;
    end else begin
      r_state       <= w_state;
      r_tx_start    <= w_tx_start;
      r_tx_data     <= w_tx_data;
      r_grant_valid <= w_grant_valid;
      r_grant_id    <= w_grant_id;
      r_err_timeout <= w_err_timeout;
      r_burst_cnt   <= w_burst_cnt;
      r_last_id     <= w_last_id;
      r_last_cap    <= w_last_cap;
      r_to_cnt      <= w_to_cnt;
    end
  end

  // Accept pulse is masked during reset so a reset landing in LOAD consumes nothing.
  assign req_ready   = wb_rst_i ? '0 : w_ready;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a UART busy model and a
// packet-level round-robin reference predicting the received byte order.
module tb_uart_tx_arbiter;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXB = 16;
  localparam int TMO  = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic [N-1:0]    req_last  = '0;
  logic [N-1:0]    req_ready;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            tx_busy = 1'b0;
  logic            grant_valid;
  logic [1:0]      grant_id;
  logic            err_timeout;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MAXB), .START_TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant_valid(grant_valid), .grant_id(grant_id),
    .err_timeout(err_timeout));

  always #5 clk = ~clk;

  logic [8:0]    q [N][$];
  int            rx_id[$], exp_id[$];
  logic [7:0]    rx_dat[$], exp_dat[$];
  int            n_cmp = 0, n_mis = 0;
  int            n_starts = 0, n_err = 0, n_rx_total = 0;
  int            n_rdy [N];
  int            busy_len = 3, ack_dly = 0, dly_left = 0, busy_left = 0;
  bit            uart_ack = 1'b1;
  int            rr_last = N - 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    q[r].push_back({l, d});
  endtask

  function automatic bit q_empty();
    for (int i = 0; i < N; i++) if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: whole packets in round-robin order, each grant ending on last,
  // on MAX_BURST bytes, or when the holder has nothing more to offer.
  task automatic model_round();
    logic [8:0] p [N][$];
    logic [8:0] e;
    int h, c, burst;
    bit done, any;
    for (int i = 0; i < N; i++) p[i] = q[i];
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int i = 0; i < N; i++) if (p[i].size() != 0) any = 1'b1;
      if (any) begin
        h = -1;
        for (int k = 1; k <= N; k++) begin
          c = (rr_last + k) % N;
          if (h < 0 && p[c].size() != 0) h = c;
        end
        burst = 0;
        done  = 1'b0;
        while (!done) begin
          if (p[h].size() == 0) done = 1'b1;
          else begin
            e = p[h].pop_front();
            exp_id.push_back(h);
            exp_dat.push_back(e[7:0]);
            burst++;
            if (e[8] || burst == MAXB) done = 1'b1;
          end
        end
        rr_last = h;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      if (q_empty() && !grant_valid && !tx_busy && !tx_start) done = 1'b1;
    end
    chk("idle_wait", 32'(done), 1);
  endtask

  task automatic compare_round(input string tag);
    chk({tag, "_count"}, 32'(rx_id.size()), 32'(exp_id.size()));
    for (int k = 0; k < rx_id.size() && k < exp_id.size(); k++) begin
      chk({tag, "_id"}, 32'(rx_id[k]), 32'(exp_id[k]));
      chk({tag, "_data"}, 32'(rx_dat[k]), 32'(exp_dat[k]));
    end
    n_rx_total += rx_id.size();
    rx_id.delete();
    rx_dat.delete();
    exp_id.delete();
    exp_dat.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rr_last = N - 1;
  endtask

  // Requester and UART models: sample mid-cycle, update just after the edge.
  initial begin : bfm
    logic [N-1:0]  rdy_s;
    logic          ts_s, prev_ts, prev_rdy;
    logic [1:0]    gid_s;
    logic [DW-1:0] txd_s, prev_txd;
    prev_ts  = 1'b0;
    prev_rdy = 1'b0;
    prev_txd = '0;
    for (int i = 0; i < N; i++) n_rdy[i] = 0;
    forever begin
      @(negedge clk);
      rdy_s = req_ready;
      ts_s  = tx_start;
      gid_s = grant_id;
      txd_s = tx_data;
      if (rdy_s != '0) begin
        chk("rdy_onehot", 32'(rdy_s), 32'(4'b0001 << gid_s));
        chk("rdy_granted", 32'(grant_valid), 1);
      end
      if (ts_s && !prev_ts) n_starts++;
      if (err_timeout) n_err++;
      if (!rst && txd_s != prev_txd) chk("txd_change_no_load", 32'(prev_rdy), 1);
      prev_ts  = ts_s;
      prev_rdy = (rdy_s != '0);
      prev_txd = txd_s;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (rdy_s[i] && q[i].size() != 0) begin
          void'(q[i].pop_front());
          n_rdy[i]++;
        end
      if (tx_busy) begin
        busy_left--;
        if (busy_left <= 0) tx_busy = 1'b0;
      end else if (ts_s && uart_ack) begin
        if (dly_left > 0) dly_left--;
        else begin
          tx_busy   = 1'b1;
          busy_left = busy_len;
          rx_id.push_back(int'(gid_s));
          rx_dat.push_back(txd_s);
          dly_left = ack_dly;
        end
      end
      for (int i = 0; i < N; i++) begin
        req_valid[i]          = (q[i].size() != 0);
        req_data[i*DW +: DW]  = (q[i].size() != 0) ? q[i][0][7:0] : '0;
        req_last[i]           = (q[i].size() != 0) ? q[i][0][8] : 1'b0;
      end
    end
  end

  initial begin : main
    int base, n, k, k1, npk, len, st0;
    bit seen, nolast;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_grant_valid", 32'(grant_valid), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_err", 32'(err_timeout), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte from requester 0: latency, data, one accept pulse.
    busy_len = 10;
    base = n_rdy[0];
    push(0, 8'h0F, 1'b1);
    model_round();
    @(negedge clk);
    chk("lat0_tx_start", 32'(tx_start), 0);
    chk("lat0_grant", 32'(grant_valid), 0);
    @(negedge clk);
    chk("lat1_tx_start", 32'(tx_start), 0);
    chk("lat1_grant", 32'(grant_valid), 1);
    chk("lat1_grant_id", 32'(grant_id), 0);
    chk("lat1_ready", 32'(req_ready), 1);
    @(negedge clk);
    chk("lat2_tx_start", 32'(tx_start), 1);
    chk("lat2_tx_data", 32'(tx_data), 32'h0F);
    wait_idle(200);
    chk("t1_ready_pulses", 32'(n_rdy[0] - base), 1);
    compare_round("single");

    // All four requesters after reset, then 0 and 2 after the pointer wraps.
    busy_len = 3;
    do_reset();
    for (int i = 0; i < N; i++) push(i, 8'(8'h10 + i), 1'b1);
    model_round();
    wait_idle(400);
    for (int i = 0; i < N && i < rx_id.size(); i++) chk("rr_order", 32'(rx_id[i]), 32'(i));
    compare_round("rr4");
    push(2, 8'h22, 1'b1);
    push(0, 8'h20, 1'b1);
    model_round();
    wait_idle(400);
    if (rx_id.size() >= 2) begin
      chk("wrap_first", 32'(rx_id[0]), 0);
      chk("wrap_second", 32'(rx_id[1]), 2);
    end else chk("wrap_count", 32'(rx_id.size()), 2);
    compare_round("wrap");

    // Requester 1 streams 20 bytes without last while requester 2 waits.
    for (int b = 0; b < 20; b++) push(1, 8'(8'h3D + b), 1'b0);
    push(2, 8'hA5, 1'b1);
    model_round();
    wait_idle(2000);
    if (rx_id.size() == 21) begin
      chk("burst_16th_id", 32'(rx_id[15]), 1);
      chk("burst_break_id", 32'(rx_id[16]), 2);
      chk("burst_resume_id", 32'(rx_id[17]), 1);
      chk("burst_resume_data", 32'(rx_dat[17]), 32'(8'h3D + 16));
    end else chk("burst_count", 32'(rx_id.size()), 21);
    compare_round("burst");

    // Start timeout: no acknowledge for the first byte, the next holder is served.
    k  = (rr_last + 1) % N;
    k1 = (k + 1) % N;
    uart_ack = 1'b0;
    push(k, 8'h77, 1'b1);
    push(k1, 8'h88, 1'b1);
    for (int m = 0; m < 30 && !tx_start; m++) @(negedge clk);
    chk("to_start_seen", 32'(tx_start), 1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (err_timeout) seen = 1'b1;
    end
    chk("to_cycles", 32'(n), TMO);
    chk("to_tx_start_low", 32'(tx_start), 0);
    chk("to_grant_dropped", 32'(grant_valid), 0);
    uart_ack = 1'b1;
    @(negedge clk);
    chk("to_err_one_cycle", 32'(err_timeout), 0);
    chk("to_next_grant", 32'(grant_valid), 1);
    chk("to_next_id", 32'(grant_id), 32'(k1));
    exp_id.push_back(k1);
    exp_dat.push_back(8'h88);
    rr_last = k1;
    wait_idle(400);
    compare_round("timeout");

    // Reset while requester 3 is in its transmit wait.
    busy_len = 10;
    push(3, 8'h5A, 1'b1);
    model_round();
    seen = 1'b0;
    for (int m = 0; m < 60 && !seen; m++) begin
      @(negedge clk);
      if (grant_valid && grant_id == 2'd3 && tx_busy && !tx_start) seen = 1'b1;
    end
    chk("rst_wait_done_reached", 32'(seen), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx_start", 32'(tx_start), 0);
    chk("mid_rst_grant_valid", 32'(grant_valid), 0);
    chk("mid_rst_grant_id", 32'(grant_id), 0);
    chk("mid_rst_tx_data", 32'(tx_data), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 0);
    chk("mid_rst_err", 32'(err_timeout), 0);
    @(negedge clk);
    rst = 1'b0;
    rr_last = N - 1;
    wait_idle(100);
    compare_round("rst_mid");
    busy_len = 3;
    push(3, 8'h63, 1'b1);
    push(0, 8'h60, 1'b1);
    model_round();
    wait_idle(400);
    if (rx_id.size() != 0) chk("post_rst_first", 32'(rx_id[0]), 0);
    else chk("post_rst_count", 32'(rx_id.size()), 2);
    compare_round("post_rst");

    // Packet abandoned after two bytes: no extra start, no extra accept.
    base = n_rdy[0];
    st0  = n_starts;
    push(0, 8'hC1, 1'b0);
    push(0, 8'hC2, 1'b0);
    model_round();
    wait_idle(400);
    chk("drop_starts", 32'(n_starts - st0), 2);
    chk("drop_readies", 32'(n_rdy[0] - base), 2);
    compare_round("drop");

    // Randomized rounds with varying transmitter timing.
    for (int r = 0; r < 12; r++) begin
      busy_len = $urandom_range(1, 6);
      ack_dly  = $urandom_range(0, 3);
      dly_left = ack_dly;
      for (int i = 0; i < N; i++) begin
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) begin
          len    = $urandom_range(1, 6);
          nolast = ($urandom_range(0, 4) == 0);
          for (int b = 0; b < len; b++) push(i, 8'($urandom), (b == len - 1) && !nolast);
        end
      end
      model_round();
      wait_idle(4000);
      compare_round("rnd");
    end

    chk("start_total", 32'(n_starts), 32'(n_rx_total + 1));
    chk("err_total", 32'(n_err), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
